// File: rtl/demux1t8_32_buf.sv
// rtl/demux1t8_32_buf.sv - registered 1-to-8 demux with per-channel valid/ready holding registers
// Each channel is a one-entry buffer (EMPTY/FULL); broadcast loads all eight when every channel is free.
module demux1t8_32_buf #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       S,
  input  logic             BCAST,
  input  logic [WIDTH-1:0] I,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] O0,
  output logic [WIDTH-1:0] O1,
  output logic [WIDTH-1:0] O2,
  output logic [WIDTH-1:0] O3,
  output logic [WIDTH-1:0] O4,
  output logic [WIDTH-1:0] O5,
  output logic [WIDTH-1:0] O6,
  output logic [WIDTH-1:0] O7,
  output logic [7:0]       O_valid,
  input  logic [7:0]       O_ready,
  output logic             busy
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } ch_state_e;

  ch_state_e        state_q [8];
  ch_state_e        state_d [8];
  logic [WIDTH-1:0] data_q  [8];
  logic [WIDTH-1:0] data_d  [8];

  logic [7:0] free;
  logic [7:0] load;
  logic       accept;

  always_comb begin
    O_valid = '0;
    for (int k = 0; k < 8; k++) begin
      O_valid[k] = (state_q[k] == FULL);
    end
  end

  // A channel can take a new word if it is empty or its consumer drains it this cycle.
  assign free     = ~O_valid | O_ready;
  assign in_ready = BCAST ? (&free) : free[S];
  assign accept   = in_valid & in_ready;
  assign busy     = |O_valid;

  always_comb begin
    load = '0;
    for (int k = 0; k < 8; k++) begin
      load[k]    = accept & (BCAST | (S == 3'(k)));
      state_d[k] = state_q[k];
      data_d[k]  = data_q[k];
      case (state_q[k])
        EMPTY: begin
          if (load[k]) begin
            state_d[k] = FULL;
            data_d[k]  = I;
          end
        end
        FULL: begin
          if (load[k]) begin
            data_d[k] = I;
          end else if (O_ready[k]) begin
            state_d[k] = EMPTY;
          end
        end
        default: state_d[k] = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < 8; k++) begin
      if (!rst_n) begin
        state_q[k] <= EMPTY;
        data_q[k]  <= '0;
      end else begin
        state_q[k] <= state_d[k];
        data_q[k]  <= data_d[k];
      end
    end
  end

  assign O0 = data_q[0];
  assign O1 = data_q[1];
  assign O2 = data_q[2];
  assign O3 = data_q[3];
  assign O4 = data_q[4];
  assign O5 = data_q[5];
  assign O6 = data_q[6];
  assign O7 = data_q[7];

endmodule
